// File: rtl/rf_pkg.sv
// rf_pkg: FunSel codes and the per-cell next-value function for param_register_file
package rf_pkg;
  localparam int MAXW = 64;
  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;
  localparam logic [2:0] FS_ROL  = 3'b100;
  localparam logic [2:0] FS_ROR  = 3'b101;
  localparam logic [2:0] FS_LSL  = 3'b110;
  localparam logic [2:0] FS_ASR  = 3'b111;
  // Values are carried in MAXW bits and masked to w bits so one function serves any width up to MAXW
  function automatic logic [MAXW-1:0] rf_next(input logic [2:0] fs, input logic [MAXW-1:0] v,
                                              input logic [MAXW-1:0] d, input int unsigned w);
    logic [MAXW-1:0] m;
    logic [MAXW-1:0] msb;
    m = (MAXW'(1) << w) - MAXW'(1);
    msb = MAXW'(1) << (w - 1);
    case (fs)
      FS_DEC:  return (v - MAXW'(1)) & m;
      FS_INC:  return (v + MAXW'(1)) & m;
      FS_LOAD: return d & m;
      FS_CLR:  return '0;
      FS_ROL:  return ((v << 1) | (v >> (w - 1))) & m;
      FS_ROR:  return (v >> 1) | ((v & MAXW'(1)) << (w - 1));
      FS_LSL:  return (v << 1) & m;
      default: return (v >> 1) | (v & msb);
    endcase
  endfunction
endpackage

// File: rtl/rf_cell.sv
// rf_cell: one live register with FunSel update, restore load and a shadow flop
module rf_cell
  import rf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_en_n,
  input  logic [2:0]       i_fun_sel,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_save,
  input  logic             i_restore,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_live;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_next;
  assign w_next = WIDTH'(rf_next(i_fun_sel, MAXW'(r_live), MAXW'(i_data), WIDTH));
  assign o_q = r_live;
  // Restore beats FunSel; save and restore together swap because both read pre-edge values
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_live <= '0;
      r_shadow <= '0;
    end else begin
      r_live <= i_restore ? r_shadow : (i_en_n ? r_live : w_next);
      r_shadow <= i_save ? r_live : r_shadow;
    end
  end
endmodule

// File: rtl/param_register_file.sv
// param_register_file: parametrised R/S register file with shadow bank; RF_BYPASS_EN adds load write-through on reads
module param_register_file
  import rf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NUM_R = 4,
  parameter int NUM_S = 4,
  localparam int SELW = $clog2(NUM_R + NUM_S)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [NUM_R-1:0] RegSel,
  input  logic [NUM_S-1:0] ScrSel,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  input  logic             Save,
  input  logic             Restore,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);
  localparam int N = NUM_R + NUM_S;
  localparam int M = 2 ** SELW;
  logic [N-1:0]     w_cat;
  logic [WIDTH-1:0] w_rd [M];
  assign w_cat = {RegSel, ScrSel};
`ifdef RF_BYPASS_EN
  logic [M-1:0] w_byp;
`endif
  for (genvar k = 0; k < M; k++) begin : g_cell
    if (k < N) begin : g_live
      rf_cell #(.WIDTH(WIDTH)) u_cell (
        .Clock     (Clock),
        .Reset     (Reset),
        .i_en_n    (w_cat[N-1-k]),
        .i_fun_sel (FunSel),
        .i_data    (I),
        .i_save    (Save),
        .i_restore (Restore),
        .o_q       (w_rd[k])
      );
`ifdef RF_BYPASS_EN
      assign w_byp[k] = !w_cat[N-1-k] && FunSel == FS_LOAD && !Restore;
`endif
    end else begin : g_pad
      assign w_rd[k] = '0;
`ifdef RF_BYPASS_EN
      assign w_byp[k] = 1'b0;
`endif
    end
  end
`ifdef RF_BYPASS_EN
  assign OutA = w_byp[OutASel] ? I : w_rd[OutASel];
  assign OutB = w_byp[OutBSel] ? I : w_rd[OutBSel];
`else
  assign OutA = w_rd[OutASel];
  assign OutB = w_rd[OutBSel];
`endif
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: directed table, bypass sequence and randomized model check of param_register_file
module tb_param_register_file;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        Reset, Save, Restore;
  logic [15:0] I, OutA, OutB;
  logic [2:0]  FunSel, OutASel, OutBSel;
  logic [3:0]  RegSel, ScrSel;
  logic        s_reset, s_save, s_restore;
  logic [15:0] s_i, s_a, s_b;
  logic [2:0]  s_fs, s_asel, s_bsel, s_rs;
  logic [1:0]  s_ss;
  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] live [8];
  logic [15:0] shad [8];
  typedef struct {
    logic rst, sv, rr;
    logic [15:0] d;
    logic [2:0] fs;
    logic [3:0] rg, sc;
    logic [2:0] a, b;
    logic [15:0] ea, eb;
  } vec_t;
  vec_t tv[$];

  param_register_file u_dut (
    .Clock(clk), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel), .ScrSel(ScrSel),
    .OutASel(OutASel), .OutBSel(OutBSel), .Save(Save), .Restore(Restore), .OutA(OutA), .OutB(OutB)
  );
  param_register_file #(.NUM_R(3), .NUM_S(2)) u_small (
    .Clock(clk), .Reset(s_reset), .I(s_i), .FunSel(s_fs), .RegSel(s_rs), .ScrSel(s_ss),
    .OutASel(s_asel), .OutBSel(s_bsel), .Save(s_save), .Restore(s_restore), .OutA(s_a), .OutB(s_b)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic sv, input logic rr, input logic [15:0] d,
                     input logic [2:0] fs, input logic [3:0] rg, input logic [3:0] sc,
                     input logic [2:0] a, input logic [2:0] b, input logic [15:0] ea, input logic [15:0] eb);
    vec_t t;
    t = '{rst, sv, rr, d, fs, rg, sc, a, b, ea, eb};
    tv.push_back(t);
  endtask

  task automatic hold();
    Reset = 0; Save = 0; Restore = 0; I = 0; FunSel = 0; RegSel = 4'hF; ScrSel = 4'hF;
  endtask

  function automatic logic en(input int k);
    return k < 4 ? !RegSel[3-k] : !ScrSel[7-k];
  endfunction

  function automatic logic [15:0] nxt(input logic [2:0] fs, input logic [15:0] v, input logic [15:0] d);
    case (fs)
      3'd0: return v - 16'd1;
      3'd1: return v + 16'd1;
      3'd2: return d;
      3'd3: return 16'd0;
      3'd4: return {v[14:0], v[15]};
      3'd5: return {v[0], v[15:1]};
      3'd6: return {v[14:0], 1'b0};
      default: return 16'($signed(v) >>> 1);
    endcase
  endfunction

  function automatic logic [15:0] exp_rd(input int sel);
`ifdef RF_BYPASS_EN
    if (FunSel == 3'd2 && !Restore && en(sel)) return I;
`endif
    return live[sel];
  endfunction

  task automatic model_step();
    logic [15:0] ol [8];
    logic [15:0] os [8];
    ol = live;
    os = shad;
    for (int k = 0; k < 8; k++) begin
      if (Reset) begin
        live[k] = 0;
        shad[k] = 0;
      end else begin
        live[k] = Restore ? os[k] : (en(k) ? nxt(FunSel, ol[k], I) : ol[k]);
        if (Save) shad[k] = ol[k];
      end
    end
  endtask

  initial begin
    hold();
    Reset = 1; OutASel = 0; OutBSel = 0;
    s_reset = 1; s_save = 0; s_restore = 0; s_i = 0; s_fs = 0; s_rs = 3'h7; s_ss = 2'h3;
    s_asel = 0; s_bsel = 0;
    // small configuration: fill every live register, then unpopulated indices must read 0
    @(posedge clk); #1;
    s_reset = 0; s_rs = 3'h0; s_ss = 2'h0; s_fs = 3'd2; s_i = 16'hFFFF;
    @(posedge clk); #1;
    s_rs = 3'h7; s_ss = 2'h3;
    for (int sel = 0; sel < 8; sel++) begin
      s_asel = 3'(sel);
      s_bsel = 3'(7 - sel);
      #1;
      chk($sformatf("small.A%0d", sel), s_a, sel < 5 ? 16'hFFFF : 16'h0000);
      chk($sformatf("small.B%0d", 7 - sel), s_b, (7 - sel) < 5 ? 16'hFFFF : 16'h0000);
    end
    //    rst sv rr d        fs    rg    sc    a  b  ea        eb
    add(1, 0, 0, 16'h0000, 3'd0, 4'hF, 4'hF, 0, 7, 16'h0000, 16'h0000);
    add(0, 0, 0, 16'hA5A5, 3'd2, 4'h7, 4'hF, 0, 1, 16'hA5A5, 16'h0000);
    add(0, 0, 0, 16'h0000, 3'd1, 4'h7, 4'hF, 0, 1, 16'hA5A6, 16'h0000);
    add(0, 0, 0, 16'h0000, 3'd1, 4'h7, 4'hF, 0, 3, 16'hA5A7, 16'h0000);
    add(0, 0, 0, 16'h0000, 3'd2, 4'hF, 4'hE, 7, 0, 16'h0000, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd0, 4'hF, 4'hE, 7, 0, 16'hFFFF, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd1, 4'hF, 4'hE, 7, 6, 16'h0000, 16'h0000);
    add(0, 0, 0, 16'h8001, 3'd2, 4'hB, 4'hF, 1, 0, 16'h8001, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd4, 4'hB, 4'hF, 1, 0, 16'h0003, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd7, 4'hB, 4'hF, 1, 0, 16'h0001, 16'hA5A7);
    add(0, 0, 0, 16'h8000, 3'd2, 4'hB, 4'hF, 1, 0, 16'h8000, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd7, 4'hB, 4'hF, 1, 0, 16'hC000, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd6, 4'hB, 4'hF, 1, 0, 16'h8000, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd5, 4'hB, 4'hF, 1, 0, 16'h4000, 16'hA5A7);
    add(0, 0, 0, 16'h0000, 3'd3, 4'hB, 4'hF, 1, 0, 16'h0000, 16'hA5A7);
    add(0, 0, 0, 16'h1234, 3'd2, 4'h7, 4'hF, 0, 1, 16'h1234, 16'h0000);
    add(0, 1, 0, 16'h0000, 3'd0, 4'hF, 4'hF, 0, 1, 16'h1234, 16'h0000);
    add(0, 0, 0, 16'h5555, 3'd2, 4'h7, 4'hF, 0, 1, 16'h5555, 16'h0000);
    add(0, 1, 1, 16'h0000, 3'd0, 4'hF, 4'hF, 0, 1, 16'h1234, 16'h0000);
    add(0, 0, 1, 16'h0000, 3'd3, 4'h0, 4'h0, 0, 1, 16'h5555, 16'h0000);
    add(0, 1, 0, 16'h7777, 3'd2, 4'h7, 4'hF, 0, 1, 16'h7777, 16'h0000);
    add(0, 0, 1, 16'h0000, 3'd0, 4'hF, 4'hF, 0, 1, 16'h5555, 16'h0000);
    add(1, 1, 1, 16'hABCD, 3'd2, 4'h0, 4'h0, 0, 7, 16'h0000, 16'h0000);
    add(0, 0, 1, 16'h0000, 3'd0, 4'hF, 4'hF, 0, 1, 16'h0000, 16'h0000);
    foreach (tv[n]) begin
      Reset = tv[n].rst; Save = tv[n].sv; Restore = tv[n].rr; I = tv[n].d;
      FunSel = tv[n].fs; RegSel = tv[n].rg; ScrSel = tv[n].sc;
      @(posedge clk); #1;
      hold();
      OutASel = tv[n].a; OutBSel = tv[n].b;
      #1;
      chk($sformatf("tv%0d.A", n), OutA, tv[n].ea);
      chk($sformatf("tv%0d.B", n), OutB, tv[n].eb);
    end
    // write-through forwarding is visible before the edge only with the bypass build
    RegSel = 4'h7; FunSel = 3'd2; I = 16'h1111;
    @(posedge clk); #1;
    hold();
    OutASel = 0; OutBSel = 1; RegSel = 4'h7; FunSel = 3'd2; I = 16'hBEEF;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp.load", OutA, 16'hBEEF);
`else
    chk("byp.load", OutA, 16'h1111);
`endif
    chk("byp.other", OutB, 16'h0000);
    Restore = 1; #1;
    chk("byp.restore", OutA, 16'h1111);
    Restore = 0; FunSel = 3'd1; #1;
    chk("byp.inc", OutA, 16'h1111);
    FunSel = 3'd2;
    @(posedge clk); #1;
    hold(); #1;
    chk("byp.after", OutA, 16'hBEEF);
    // randomized run against the reference model
    Reset = 1;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom % 64) == 0;
      Save = ($urandom % 6) == 0;
      Restore = ($urandom % 6) == 0;
      I = 16'($urandom);
      FunSel = 3'($urandom);
      RegSel = 4'($urandom);
      ScrSel = 4'($urandom);
      OutASel = 3'($urandom);
      OutBSel = 3'($urandom);
      #1;
      chk($sformatf("rnd%0d.A", c), OutA, exp_rd(int'(OutASel)));
      chk($sformatf("rnd%0d.B", c), OutB, exp_rd(int'(OutBSel)));
      @(posedge clk);
      model_step();
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
